// File: rtl/dir_link_rx.sv
// Direction-link UART receiver: 8N1 frames {sync 4'hA, parity, code} decoded into snake_pkg::direction.
// Optional odd-parity check on bits[3:0] is enabled by defining DIR_LINK_RX_PARITY_EN.
package snake_pkg;
  typedef enum logic [2:0] {NONE, UP, DOWN, RIGHT, LEFT} direction;
endpackage

module dir_link_rx #(
  parameter int CLK_HZ = 65_000_000,
  parameter int BAUD   = 115_200,
  parameter int OSR    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output snake_pkg::direction dir,
  output logic                rcvdir,
  output logic                frame_err,
  output logic [7:0]          err_cnt,
  output logic [1:0]          dbg_state
);
  import snake_pkg::*;

  localparam int DIV_RAW = CLK_HZ / (BAUD * OSR);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW      = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);

  // dbg_state encoding: 0 IDLE, 1 START, 2 DATA, 3 STOP
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_rxs, r_prev;
  logic [PW-1:0]   r_presc;
  logic [TW-1:0]   r_tcnt;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_chk, r_stop;
  direction        r_dir, w_map;
  logic            r_rcvdir, r_frame_err;
  logic [7:0]      r_err_cnt;

  logic w_tick, w_fall, w_restart, w_tcnt_clr, w_shift, w_stop_smp, w_valid;

  assign w_tick = (r_presc == P_LAST);
  // A break leaves r_prev low, so only a fresh high-to-low transition re-arms IDLE.
  assign w_fall = r_prev & ~r_rxs;

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_tcnt_clr  = 1'b0;
    w_shift     = 1'b0;
    w_stop_smp  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
          w_restart   = 1'b1;
        end
      end
      S_START: begin
        if (w_tick && r_tcnt == T_HALF) begin
          if (r_rxs) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_tcnt_clr  = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_tick && r_tcnt == T_LAST) begin
          w_shift    = 1'b1;
          w_tcnt_clr = 1'b1;
          if (r_bitcnt == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick && r_tcnt == T_LAST) begin
          w_stop_smp  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_map = NONE;
    case (r_shift[2:0])
      3'd1:    w_map = UP;
      3'd2:    w_map = DOWN;
      3'd3:    w_map = RIGHT;
      3'd4:    w_map = LEFT;
      default: w_map = NONE;
    endcase
  end

`ifdef DIR_LINK_RX_PARITY_EN
  assign w_valid = r_stop && (r_shift[7:4] == 4'hA) && (r_shift[2:0] <= 3'd4) && (^r_shift[3:0]);
`else
  assign w_valid = r_stop && (r_shift[7:4] == 4'hA) && (r_shift[2:0] <= 3'd4);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_rxs       <= 1'b1;
      r_prev      <= 1'b1;
      r_presc     <= '0;
      r_tcnt      <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_chk       <= 1'b0;
      r_stop      <= 1'b0;
      r_dir       <= NONE;
      r_rcvdir    <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
      r_prev  <= r_rxs;

      if (w_restart || w_tick) r_presc <= '0;
      else                     r_presc <= r_presc + 1'b1;

      if (w_restart || w_tcnt_clr) r_tcnt <= '0;
      else if (w_tick)             r_tcnt <= r_tcnt + 1'b1;

      if (w_restart)    r_bitcnt <= '0;
      else if (w_shift) r_bitcnt <= r_bitcnt + 1'b1;

      if (w_shift) r_shift <= {r_rxs, r_shift[7:1]};

      // Validation runs one cycle after the stop sample so the pulse lands on the following edge.
      r_chk <= w_stop_smp;
      if (w_stop_smp) r_stop <= r_rxs;

      r_rcvdir    <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_chk) begin
        if (w_valid) begin
          r_dir    <= w_map;
          r_rcvdir <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  assign dir       = r_dir;
  assign rcvdir    = r_rcvdir;
  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_dir_link_rx.sv
// Bench for dir_link_rx: frame-level model (expected pulse queue) checked every cycle, plus literal pins.
// A second instance at divisor 1 exercises err_cnt saturation quickly.
module tb_dir_link_rx;
  import snake_pkg::*;

  localparam int BIT  = 64;
  localparam int BIT2 = 16;
`ifdef DIR_LINK_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rx2 = 1'b1;
  direction   dir, dir2;
  logic       rcvdir, frame_err, rcvdir2, frame_err2;
  logic [7:0] err_cnt, err_cnt2;
  logic [1:0] dbg, dbg2;

  dir_link_rx #(.CLK_HZ(7_372_800), .BAUD(115_200), .OSR(16)) u_dut (
    .clk(clk), .rst(rst), .rx(rx), .dir(dir), .rcvdir(rcvdir),
    .frame_err(frame_err), .err_cnt(err_cnt), .dbg_state(dbg)
  );

  dir_link_rx #(.CLK_HZ(1_843_200), .BAUD(115_200), .OSR(16)) u_sat (
    .clk(clk), .rst(rst), .rx(rx2), .dir(dir2), .rcvdir(rcvdir2),
    .frame_err(frame_err2), .err_cnt(err_cnt2), .dbg_state(dbg2)
  );

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard: {is_error, code} per frame, plus the cycle its start bit began
  logic [3:0] exp_q[$];
  int         t0_q[$];
  direction   m_dir = NONE;
  int         m_err = 0;
  logic       mon_en = 1'b0;
  int         n_rcv = 0, n_ferr = 0, sat_pulses = 0, sat_rcv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic direction map_code(input logic [2:0] c);
    case (c)
      3'd1:    return UP;
      3'd2:    return DOWN;
      3'd3:    return RIGHT;
      3'd4:    return LEFT;
      default: return NONE;
    endcase
  endfunction

  function automatic logic frame_ok(input logic [7:0] b, input logic stop);
    logic ok;
    ok = stop && (b[7:4] == 4'hA) && (b[2:0] <= 3'd4);
    if (PAR == 1) ok = ok && (^b[3:0]);
    return ok;
  endfunction

  // compare process
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      logic [3:0] e;
      int t;
      check("pulse_overlap", 32'(rcvdir & frame_err), 32'd0);
      if (rcvdir || frame_err) begin
        check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          t = t0_q.pop_front();
          check("pulse_kind", 32'(frame_err), 32'(e[3]));
          if (!e[3]) m_dir = map_code(e[2:0]);
          else if (m_err < 255) m_err++;
          check("pulse_latency", 32'((cyc - t >= 608) && (cyc - t <= 616)), 32'd1);
        end
      end
      check("dir", 32'(dir), 32'(m_dir));
      check("err_cnt", 32'(err_cnt), 32'(m_err));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rcvdir)     n_rcv++;
      if (frame_err)  n_ferr++;
      if (frame_err2) sat_pulses++;
      if (rcvdir2)    sat_rcv++;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    @(posedge clk); #1; rx = 1'b1;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    exp_q.push_back({~frame_ok(b, stop), b[2:0]});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; rx = f[i];
      if (i == 0) t0_q.push_back(cyc);
      repeat (BIT - 1) @(posedge clk);
    end
  endtask

  task automatic send_sat(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; rx2 = f[i];
      repeat (BIT2 - 1) @(posedge clk);
    end
  endtask

  initial begin
    int rcv0, ferr0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_dir", 32'(dir), 32'(NONE));
    check("rst_rcvdir", 32'(rcvdir), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_state", 32'(dbg), 32'd0);
    mon_en = 1'b1;
    idle(BIT);

    send_frame(8'hA1, 1'b1);
    idle(BIT);
    check("a1_dir", 32'(dir), 32'(UP));
    check("a1_rcv", 32'(n_rcv), 32'd1);
    check("a1_err", 32'(err_cnt), 32'd0);

    send_frame(8'hA2, 1'b1);
    send_frame(8'hAB, 1'b1);
    send_frame(8'hA4, 1'b1);
    send_frame(8'hA8, 1'b1);
    idle(BIT);
    check("b2b_dir", 32'(dir), 32'(NONE));
    check("b2b_rcv", 32'(n_rcv), 32'd5);
    check("b2b_ferr", 32'(n_ferr), 32'd0);

    send_frame(8'hA9, 1'b1);
    idle(BIT);
    check("a9_dir", 32'(dir), 32'(PAR ? NONE : UP));
    check("a9_rcv", 32'(n_rcv), 32'(6 - PAR));
    check("a9_err", 32'(err_cnt), 32'(PAR));

    send_frame(8'hB1, 1'b1);
    send_frame(8'hA6, 1'b1);
    send_frame(8'hA1, 1'b0);
    repeat (50 * BIT) @(posedge clk);
    check("break_ferr", 32'(n_ferr), 32'(3 + PAR));
    idle(2 * BIT);
    check("break_err_cnt", 32'(err_cnt), 32'(3 + PAR));
    check("break_rcv", 32'(n_rcv), 32'(6 - PAR));

    rcv0 = n_rcv; ferr0 = n_ferr;
    @(posedge clk); #1; rx = 1'b0;
    repeat (19) @(posedge clk);
    idle(2 * BIT);
    check("glitch_rcv", 32'(n_rcv), 32'(rcv0));
    check("glitch_ferr", 32'(n_ferr), 32'(ferr0));
    check("glitch_idle", 32'(dbg), 32'd0);

    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      logic       stop;
      b[7:4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hA;
      b[3:0] = 4'($urandom_range(0, 15));
      stop   = ($urandom_range(0, 5) != 0);
      send_frame(b, stop);
      if (!stop || $urandom_range(0, 1) == 1) idle(BIT * $urandom_range(1, 3));
    end
    idle(2 * BIT);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    begin
      logic [9:0] f;
      f = {1'b1, 8'hA3, 1'b0};
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1; rx = f[i];
        repeat (BIT - 1) @(posedge clk);
      end
      @(posedge clk); #1; rx = f[5];
      repeat (BIT / 2) @(posedge clk);
      #1 rst = 1'b1; mon_en = 1'b0;
      rcv0 = n_rcv; ferr0 = n_ferr;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; rx = 1'b1;
      m_dir = NONE; m_err = 0;
      exp_q.delete(); t0_q.delete();
    end
    @(negedge clk);
    check("midrst_dir", 32'(dir), 32'(NONE));
    check("midrst_err", 32'(err_cnt), 32'd0);
    mon_en = 1'b1;
    idle(BIT);
    check("midrst_nopulse", 32'(n_rcv + n_ferr), 32'(rcv0 + ferr0));
    send_frame(8'hA3, 1'b1);
    idle(BIT);
    check("a3_dir", 32'(dir), 32'(PAR ? NONE : RIGHT));
    check("a3_err", 32'(err_cnt), 32'(PAR));
    check("final_queue", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    for (int n = 1; n <= 260; n++) begin
      send_sat(8'hB0);
      if (n == 254) begin
        @(negedge clk);
        check("sat_254", 32'(err_cnt2), 32'd254);
      end
    end
    idle(BIT2);
    check("sat_err_cnt", 32'(err_cnt2), 32'((260 < 255) ? 260 : 255));
    check("sat_pulses", 32'(sat_pulses), 32'd260);
    check("sat_no_rcv", 32'(sat_rcv), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
